instr_fetch: RTL and testbench

Instruction fetch unit for the single-cycle 9-bit processor: holds the program counter, the instruction memory and the 32-entry jump-target table, and drives `Instruction` into `Ctrl`. It consumes `Ctrl`'s `Jump_en`, `Jump_address` and `Halt` to choose the next PC. It also owns the run/halt sequencing: program load, start and done.

---
 rtl/instr_fetch.sv | 119 +++++++++++
 tb/tb_instr_fetch.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
//==============================================================================
// Module      : instr_fetch
// Description : PC, instruction memory, jump-target table and run/halt control
//               for the single-cycle 9-bit processor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_fetch #(
  parameter int PC_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 Load_en,
  input  logic                 Load_sel,
  input  logic [PC_WIDTH-1:0]  Load_addr,
  input  logic [8:0]           Load_data,
  input  logic                 Jump_en,
  input  logic [4:0]           Jump_address,
  input  logic                 Halt,
  output logic [8:0]           Instruction,
  output logic [PC_WIDTH-1:0]  PC,
  output logic                 Valid,
  output logic                 Done,
  output logic [CNT_WIDTH-1:0] Retired
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_RUN    = 2'd1;
  localparam logic [1:0] c_HALTED = 2'd2;

  localparam logic [PC_WIDTH-1:0]  c_PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  // Neither memory is reset, so a program survives a Reset pulse.
  logic [8:0]           imem_q [2**PC_WIDTH];
  logic [PC_WIDTH-1:0]  jtab_q [32];

  logic [4:0]           w_jtab_addr;
  logic                 w_load_ok;

  generate
    if (PC_WIDTH >= 5) begin : g_jaddr_wide
      assign w_jtab_addr = Load_addr[4:0];
    end else begin : g_jaddr_narrow
      assign w_jtab_addr = {{(5-PC_WIDTH){1'b0}}, Load_addr};
    end
  endgenerate

  assign w_load_ok = Load_en & ~Reset & (state_q != c_RUN);

  always_ff @(posedge CLK) begin
    if (w_load_ok) begin
      if (!Load_sel) begin
        imem_q[Load_addr] <= Load_data;
      end else begin
        jtab_q[w_jtab_addr] <= Load_data[PC_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    case (state_q)
      c_IDLE, c_HALTED: begin
        if (Start) begin
          state_d   = c_RUN;
          pc_d      = '0;
          retired_d = '0;
        end
      end
      c_RUN: begin
        if (~&retired_q) begin
          retired_d = retired_q + c_CNT_ONE;
        end
        // Halt beats a simultaneous jump; PC stays on the halt instruction.
        if (Halt) begin
          state_d = c_HALTED;
        end else if (Jump_en) begin
          pc_d = jtab_q[Jump_address];
        end else begin
          pc_d = pc_q + c_PC_ONE;
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= c_IDLE;
      pc_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  assign Instruction = imem_q[pc_q];
  assign PC          = pc_q;
  assign Valid       = (state_q == c_RUN);
  assign Done        = (state_q == c_HALTED);
  assign Retired     = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
//==============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch (8-bit and 4-bit PC).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_instr_fetch;

  logic clk;
  logic rst;

  // Instance A: default widths
  logic        a_start, a_load_en, a_load_sel, a_jump_en, a_halt_force;
  logic [7:0]  a_load_addr;
  logic [8:0]  a_load_data;
  logic [4:0]  a_jump_addr;
  logic        a_halt;
  logic [8:0]  a_instr;
  logic [7:0]  a_pc;
  logic        a_valid, a_done;
  logic [15:0] a_retired;

  // Instance B: 4-bit PC, 4-bit counter (wrap and saturation)
  logic        b_start, b_load_en;
  logic [3:0]  b_load_addr;
  logic [8:0]  b_load_data;
  logic [8:0]  b_instr;
  logic [3:0]  b_pc;
  logic        b_valid, b_done;
  logic [3:0]  b_retired;
  logic        b_zero;

  int n_checks;
  int n_err;

  // Stub decoder: 9'h1C0 is the halt opcode, plus a forced halt for directed cases.
  assign a_halt = (a_instr == 9'h1C0) | a_halt_force;
  assign b_zero = 1'b0;

  instr_fetch #(.PC_WIDTH(8), .CNT_WIDTH(16)) u_dut_a (
    .CLK(clk), .Reset(rst), .Start(a_start), .Load_en(a_load_en),
    .Load_sel(a_load_sel), .Load_addr(a_load_addr), .Load_data(a_load_data),
    .Jump_en(a_jump_en), .Jump_address(a_jump_addr), .Halt(a_halt),
    .Instruction(a_instr), .PC(a_pc), .Valid(a_valid), .Done(a_done),
    .Retired(a_retired)
  );

  instr_fetch #(.PC_WIDTH(4), .CNT_WIDTH(4)) u_dut_b (
    .CLK(clk), .Reset(rst), .Start(b_start), .Load_en(b_load_en),
    .Load_sel(b_zero), .Load_addr(b_load_addr), .Load_data(b_load_data),
    .Jump_en(b_zero), .Jump_address(5'd0), .Halt(b_zero),
    .Instruction(b_instr), .PC(b_pc), .Valid(b_valid), .Done(b_done),
    .Retired(b_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input logic sel, input logic [7:0] addr, input logic [8:0] data);
    a_load_en = 1'b1; a_load_sel = sel; a_load_addr = addr; a_load_data = data;
    step();
    a_load_en = 1'b0;
  endtask

  task automatic load_b(input logic [3:0] addr, input logic [8:0] data);
    b_load_en = 1'b1; b_load_addr = addr; b_load_data = data;
    step();
    b_load_en = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    rst = 1'b1;
    a_start = 0; a_load_en = 0; a_load_sel = 0; a_jump_en = 0; a_halt_force = 0;
    a_load_addr = '0; a_load_data = '0; a_jump_addr = '0;
    b_start = 0; b_load_en = 0; b_load_addr = '0; b_load_data = '0;

    // Reset for two cycles, then idle
    step(); step();
    chk("rst_pc", a_pc, 0); chk("rst_valid", a_valid, 0);
    chk("rst_done", a_done, 0); chk("rst_retired", a_retired, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_pc", a_pc, 0); chk("idle_valid", a_valid, 0);
      chk("idle_done", a_done, 0); chk("idle_retired", a_retired, 0);
    end

    // Sequential run to a halt at PC 3
    load_a(0, 8'd0, 9'h00C); load_a(0, 8'd1, 9'h01D);
    load_a(0, 8'd2, 9'h059); load_a(0, 8'd3, 9'h1C0);
    chk("idle_instr", a_instr, 9'h00C);
    a_start = 1'b1; step(); a_start = 1'b0;
    chk("run_valid", a_valid, 1);
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", a_pc, i);
      chk("seq_retired", a_retired, i);
      step();
    end
    chk("halt_done", a_done, 1); chk("halt_valid", a_valid, 0);
    chk("halt_pc", a_pc, 3); chk("halt_retired", a_retired, 4);

    // Jump via jtab[5] at PC 2; Start during RUN is ignored
    load_a(1, 8'd5, 9'h040);
    load_a(0, 8'h40, 9'h001); load_a(0, 8'h41, 9'h001); load_a(0, 8'h42, 9'h1C0);
    chk("still_halted", a_done, 1);
    a_start = 1'b1; step(); a_start = 1'b0;
    chk("restart_pc", a_pc, 0); chk("restart_retired", a_retired, 0);
    chk("restart_done", a_done, 0);
    step();
    a_start = 1'b1; step(); a_start = 1'b0;
    chk("start_ignored_pc", a_pc, 2);
    a_jump_en = 1'b1; a_jump_addr = 5'd5; step(); a_jump_en = 1'b0;
    chk("jump_pc", a_pc, 8'h40);
    step(); chk("jump_next_pc", a_pc, 8'h41);
    step(); chk("jump_halt_instr", a_instr, 9'h1C0);
    step();
    chk("jump_run_done", a_done, 1); chk("jump_run_pc", a_pc, 8'h42);
    chk("jump_run_retired", a_retired, 6);

    // Run to PC 7 with a RUN-time load attempt; then Halt+Jump together
    load_a(0, 8'd3, 9'h059);
    for (int i = 4; i < 8; i++) load_a(0, 8'(i), 9'h001);
    a_start = 1'b1; step(); a_start = 1'b0;
    step();
    a_load_en = 1'b1; a_load_sel = 1'b0; a_load_addr = 8'd1; a_load_data = 9'h1C0;
    step(); a_load_en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("pre_prio_pc", a_pc, 7);
    a_jump_en = 1'b1; a_jump_addr = 5'd5; a_halt_force = 1'b1;
    step();
    a_jump_en = 1'b0; a_halt_force = 1'b0;
    chk("prio_done", a_done, 1); chk("prio_pc", a_pc, 7);
    chk("prio_retired", a_retired, 8);

    // Load and Start in the same HALTED cycle
    a_load_en = 1'b1; a_load_sel = 1'b0; a_load_addr = 8'd0; a_load_data = 9'h0AA;
    a_start = 1'b1;
    step();
    a_load_en = 1'b0; a_start = 1'b0;
    chk("ls_valid", a_valid, 1); chk("ls_pc", a_pc, 0);
    chk("ls_instr", a_instr, 9'h0AA);
    step();
    chk("protect_instr", a_instr, 9'h01D);
    a_halt_force = 1'b1; step(); step(); a_halt_force = 1'b0;
    chk("ls_halt_pc", a_pc, 1); chk("ls_halt_retired", a_retired, 2);

    // Instance B: wrap 15 -> 0, counter saturation, reset mid-run
    for (int i = 0; i < 16; i++) load_b(4'(i), 9'(9'h010 + i));
    b_start = 1'b1; step(); b_start = 1'b0;
    chk("b_start_pc", b_pc, 0); chk("b_start_instr", b_instr, 9'h010);
    for (int i = 1; i < 16; i++) step();
    chk("b_pc15", b_pc, 15); chk("b_ret15", b_retired, 15);
    step();
    chk("b_wrap_pc", b_pc, 0); chk("b_sat_retired", b_retired, 15);
    for (int i = 0; i < 9; i++) step();
    chk("b_pc9", b_pc, 9); chk("b_pc9_instr", b_instr, 9'h019);
    rst = 1'b1; step(); rst = 1'b0;
    chk("b_rst_pc", b_pc, 0); chk("b_rst_valid", b_valid, 0);
    chk("b_rst_retired", b_retired, 0); chk("b_rst_instr", b_instr, 9'h010);
    b_start = 1'b1; step(); b_start = 1'b0;
    chk("b_rerun_valid", b_valid, 1); chk("b_rerun_instr", b_instr, 9'h010);
    step();
    chk("b_rerun_pc", b_pc, 1); chk("b_rerun_instr1", b_instr, 9'h011);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

`default_nettype wire
